bram_row_reader: RTL

- Read-side sequencer for bram_coupler: waits for the coupler's full flag, then sweeps read addresses 0..row_width-1 with r_en.
- Captures each ROWS-wide word on the coupler's valid and presents it downstream on a valid/ready stream through a small FIFO.
- Credit-based issue: a read is issued only when its result is guaranteed FIFO space, so downstream backpressure never drops data.

---
 rtl/bram_row_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bram_row_reader.sv
// bram_row_reader: read-side sequencer for bram_coupler. It waits for the
// coupler's full flag, sweeps read addresses 0..len-1 and streams the words.
// Ports:
//   clk, rst        clock, async active-low reset
//   row_width,start sweep length (sampled on accepted start) and start pulse
//   full            coupler full flag
//   r_add, r_en     read address / strobe to the coupler (registered)
//   data_out, valid coupler read data and its valid
//   m_data, m_valid, m_ready  downstream valid/ready stream (FIFO head)
//   busy, done, err not-idle flag, end-of-sweep pulse, sticky spurious-valid
module bram_row_reader #(
    parameter int BUS_WIDTH     = 32,
    parameter int ROWS          = 1,
    parameter int MAX_ROW_WIDTH = 1024,
    parameter int ADDR_WIDTH    = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH:0]       row_width,
    input  logic                      start,
    input  logic                      full,
    output logic [ADDR_WIDTH-1:0]     r_add,
    output logic                      r_en,
    input  logic [ROWS*BUS_WIDTH-1:0] data_out,
    input  logic                      valid,
    output logic [ROWS*BUS_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int DW = ROWS * BUS_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = ADDR_WIDTH + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         len_q, len_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         len_in;
    logic                  r_en_q;
    logic [ADDR_WIDTH-1:0] r_add_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_q, rd_q;
    logic [DW-1:0]         mem [FIFO_DEPTH];

    logic                  issue;
    logic                  last;
    logic                  credit;
    logic [CW+1:0]         used;
    logic                  push;
    logic                  pop;

    assign len_in = (row_width > AW'(MAX_ROW_WIDTH)) ? AW'(MAX_ROW_WIDTH)
                                                     : row_width;

    // Every read whose data could still land in the FIFO holds a slot:
    // buffered words, reads in flight, and the strobe now on the wire.
    assign used   = (CW+2)'(cnt_q) + (CW+2)'(outst_q) + (CW+2)'(r_en_q);
    assign credit = used < (CW+2)'(FIFO_DEPTH);
    assign last   = addr_q == (len_q - AW'(1));

    assign push = valid && (outst_q != '0);
    assign pop  = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_in;
                    addr_d  = '0;
                    state_d = (len_in == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // First read goes out in the same cycle full is seen.
                if (full) begin
                    state_d = S_ISSUE;
                    issue   = credit;
                end
            end
            S_ISSUE: issue = credit;
            S_DRAIN: begin
                if (outst_q == '0 && !r_en_q && cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            addr_d = addr_q + AW'(1);
            if (last) begin
                state_d = S_DRAIN;
            end
        end
    end

    assign outst_d = outst_q + CW'(r_en_q) - CW'(push);
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            r_en_q  <= 1'b0;
            r_add_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            outst_q <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            r_en_q  <= issue;
            if (issue) begin
                r_add_q <= addr_q[ADDR_WIDTH-1:0];
            end
            busy_q  <= state_d != S_IDLE;
            done_q  <= state_q == S_DONE;
            if (valid && outst_q == '0) begin
                err_q <= 1'b1;
            end
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= data_out;
        end
    end

    assign r_en    = r_en_q;
    assign r_add   = r_add_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign m_valid = cnt_q != '0;
    assign m_data  = m_valid ? mem[rd_q] : '0;

endmodule
